// File: rtl/stream_mux_rr_pkg.sv
// rtl/stream_mux_rr_pkg.sv - shared constants and helpers for the stream_mux_rr slice
//
// Purpose : selection-mode encodings shared by the mux, its arbiter and benches,
//           plus the wrap-around pointer increment used by round-robin selection.
package stream_mux_rr_pkg;

  // Selection mode encodings for the MODE parameter of stream_mux_rr.
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Next round-robin start position after channel idx won, among n channels.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational rotating-priority search for stream_mux_rr
//
// Purpose : find the first asserted request at or after ptr, wrapping past N-1 to 0.
// Ports   :
//   req          in   N     request vector (one bit per channel)
//   ptr          in   SELW  highest-priority channel this cycle (always < N)
//   grant_idx    out  SELW  winning channel (0 when grant_valid is low)
//   grant_valid  out  1     some request was found
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_valid
);
  import stream_mux_rr_pkg::*;

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int idx;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Walk offsets from farthest to nearest so the closest request to ptr
    // is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[idx[IW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream multiplexer, fixed or round-robin select
//
// Purpose : choose one of N valid/ready input channels (by external sel, or
//           round-robin among valid channels) and register the chosen word
//           into a single output stage with full-throughput handshaking.
// Ports   :
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous active-low reset
//   in_data    in   N*WIDTH  channel i word at [i*WIDTH +: WIDTH]
//   in_valid   in   N        channel i offers a word
//   in_ready   out  N        channel i word taken this cycle (at most one bit high)
//   sel        in   SELW     channel index, fixed mode only
//   out_data   out  WIDTH    registered word
//   out_chan   out  SELW     channel that supplied out_data
//   out_valid  out  1        output register holds a word
//   out_ready  in   1        downstream takes the word
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = MODE_FIXED,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] grant_word;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] ptr_q, ptr_d;
      logic            sel_unused;

      assign sel_unused = ^sel;

      rr_arbiter #(
        .N    (N),
        .SELW (SELW)
      ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
      );

      // Pointer moves just past the winner only when a word is actually taken,
      // so a stalled or idle cycle never costs a channel its turn.
      always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
          ptr_d = SELW'(wrap_inc(int'(grant_idx), N));
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end else begin : g_fixed
      // An out-of-range sel matches no channel and so never grants.
      // With a single channel, sel is ignored and channel 0 is always the candidate.
      always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
          if ((N == 1 || sel == SELW'(i)) && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SELW'(i);
          end
        end
      end
    end
  endgenerate

  // Word of the granted channel.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The register can take a new word when empty or when its current word
  // leaves this same cycle; that is what gives one word per cycle.
  always_comb begin
    load   = !out_valid_q || out_ready;
    accept = reset_n && load && grant_valid;
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && grant_idx == SELW'(i)) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  // Draining with nothing granted empties the register but keeps the last
  // data/channel visible for consumers that look at them while invalid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_chan_d  = grant_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr in fixed and round-robin modes
module tb_stream_mux_rr;
  import stream_mux_rr_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  f_in_ready, r_in_ready;
  logic [15:0] f_out_data, r_out_data;
  logic [1:0]  f_out_chan, r_out_chan;
  logic        f_out_valid, r_out_valid;

  int total;
  int bad;

  // Scoreboard state
  logic        sb_en;
  int          sb_mode;
  logic [17:0] sbq[$];
  logic        m_valid;
  int          m_ptr;
  int          pushes;
  int          pops;

  stream_mux_rr #(.WIDTH(16), .N(4), .MODE(MODE_FIXED), .SELW(2)) u_fix (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (f_in_ready),
    .sel       (sel),
    .out_data  (f_out_data),
    .out_chan  (f_out_chan),
    .out_valid (f_out_valid),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.WIDTH(16), .N(4), .MODE(MODE_RR), .SELW(2)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (r_in_ready),
    .sel       (sel),
    .out_data  (r_out_data),
    .out_chan  (r_out_chan),
    .out_valid (r_out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model + scoreboard, evaluated mid-cycle after inputs settle.
  always @(negedge clk) begin
    logic [3:0]  exp_rdy;
    logic [3:0]  act_rdy;
    logic        act_ov;
    logic [15:0] act_od;
    logic [1:0]  act_oc;
    logic        ld;
    logic        gv;
    int          g;
    int          c;
    logic [17:0] e;
    if (!sb_en) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sbq.delete();
    end else begin
      act_rdy = (sb_mode == MODE_RR) ? r_in_ready  : f_in_ready;
      act_ov  = (sb_mode == MODE_RR) ? r_out_valid : f_out_valid;
      act_od  = (sb_mode == MODE_RR) ? r_out_data  : f_out_data;
      act_oc  = (sb_mode == MODE_RR) ? r_out_chan  : f_out_chan;
      ld = !m_valid || out_ready;
      gv = 1'b0;
      g  = 0;
      if (sb_mode == MODE_FIXED) begin
        if (in_valid[sel]) begin
          gv = 1'b1;
          g  = int'(sel);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!gv && in_valid[c]) begin
            gv = 1'b1;
            g  = c;
          end
        end
      end
      exp_rdy = (ld && gv) ? (4'b0001 << g) : 4'b0000;
      total++;
      if (act_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL sb_in_ready t=%0t got=%b want=%b", $time, act_rdy, exp_rdy);
      end
      total++;
      if (act_ov !== m_valid) begin
        bad++;
        $display("FAIL sb_out_valid t=%0t got=%b want=%b", $time, act_ov, m_valid);
      end
      if (m_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow t=%0t got=%h want=<none>", $time, {act_oc, act_od});
        end else begin
          e = sbq.pop_front();
          pops++;
          if ({act_oc, act_od} !== e) begin
            bad++;
            $display("FAIL sb_word t=%0t got=%0d:%h want=%0d:%h", $time, act_oc, act_od, e[17:16], e[15:0]);
          end
        end
      end
      if (ld && gv) begin
        sbq.push_back({g[1:0], in_data[g*16 +: 16]});
        pushes++;
        m_ptr = (g == 3) ? 0 : g + 1;
      end
      if (ld) m_valid = ld && gv;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [15:0] w);
    in_data[ch*16 +: 16] = w;
  endtask

  task automatic do_reset();
    sb_en   = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    sb_en     = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 64'h0004_0003_0002_0001;
    sel       = 2'd1;
    out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (f_in_ready !== 4'b0000 || r_in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready got=%b/%b want=0000", f_in_ready, r_in_ready);
    end
    total++;
    if ({f_out_valid, f_out_data, f_out_chan} !== 19'd0 || {r_out_valid, r_out_data, r_out_chan} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b,%h,%0d / %b,%h,%0d want=0", f_out_valid, f_out_data, f_out_chan,
               r_out_valid, r_out_data, r_out_chan);
    end
    reset_n  = 1'b1;
    in_valid = 4'b0000;
    tick();
    // Load a word, stall it, then reset between edges.
    sel       = 2'd3;
    set_word(3, 16'h1234);
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    tick();
    in_valid = 4'b0000;
    total++;
    if (f_out_valid !== 1'b1 || f_out_data !== 16'h1234 || f_out_chan !== 2'd3) begin
      bad++;
      $display("FAIL reset_preload got=%b,%h,%0d want=1,1234,3", f_out_valid, f_out_data, f_out_chan);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (f_out_valid !== 1'b0 || f_out_data !== 16'h0000 || f_out_chan !== 2'd0) begin
      bad++;
      $display("FAIL reset_async got=%b,%h,%0d want=0,0000,0", f_out_valid, f_out_data, f_out_chan);
    end
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_fixed_basic();
    do_reset();
    sb_mode   = MODE_FIXED;
    sb_en     = 1'b1;
    sel       = 2'd2;
    in_data   = 64'h0;
    set_word(2, 16'hBEEF);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    total++;
    if (f_in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL fixed_in_ready got=%b want=0100", f_in_ready);
    end
    tick();
    in_valid = 4'b0000;
    total++;
    if (f_out_valid !== 1'b1 || f_out_data !== 16'hBEEF || f_out_chan !== 2'd2) begin
      bad++;
      $display("FAIL fixed_out got=%b,%h,%0d want=1,beef,2", f_out_valid, f_out_data, f_out_chan);
    end
    tick();
    total++;
    if (f_out_valid !== 1'b0 || f_out_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL fixed_hold_idle got=%b,%h want=0,beef", f_out_valid, f_out_data);
    end
    // sel pointing at an idle channel never grants
    sel      = 2'd0;
    in_valid = 4'b1110;
    #1;
    total++;
    if (f_in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL fixed_idle_sel got=%b want=0000", f_in_ready);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fixed_stall();
    sel       = 2'd1;
    set_word(1, 16'hA1A1);
    set_word(3, 16'hC3C3);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    tick();
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      sel = (c % 2 == 0) ? 2'd3 : 2'd1;
      #1;
      total++;
      if (f_in_ready !== 4'b0000 || f_out_data !== 16'hA1A1 || f_out_chan !== 2'd1 || f_out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_c%0d got=%b,%h,%0d,%b want=0000,a1a1,1,1", c, f_in_ready, f_out_data, f_out_chan, f_out_valid);
      end
      tick();
    end
    sel       = 2'd3;
    out_ready = 1'b1;
    #1;
    total++;
    if (f_in_ready !== 4'b1000) begin
      bad++;
      $display("FAIL stall_release_ready got=%b want=1000", f_in_ready);
    end
    tick();
    in_valid = 4'b0000;
    total++;
    if (f_out_valid !== 1'b1 || f_out_data !== 16'hC3C3 || f_out_chan !== 2'd3) begin
      bad++;
      $display("FAIL stall_no_bubble got=%b,%h,%0d want=1,c3c3,3", f_out_valid, f_out_data, f_out_chan);
    end
    tick();
  endtask

  task automatic test_random(input int mode);
    sb_mode = mode;
    sb_en   = 1'b1;
    for (int c = 0; c < 60; c++) begin
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      tick();
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL random_m%0d_drain got=%0d want=0", mode, sbq.size());
    end
  endtask

  task automatic test_rr_fair();
    do_reset();
    sb_mode   = MODE_RR;
    sb_en     = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, 16'h0010 + 16'(i));
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) in_valid = 4'b0000;
      total++;
      if (r_out_valid !== 1'b1 || r_out_chan !== 2'(k % 4) || r_out_data !== 16'h0010 + 16'(k % 4)) begin
        bad++;
        $display("FAIL rr_fair_k%0d got=%b,%0d,%h want=1,%0d,%h", k, r_out_valid, r_out_chan, r_out_data,
                 k % 4, 16'h0010 + 16'(k % 4));
      end
    end
    tick();
  endtask

  task automatic test_rr_skip_wrap();
    do_reset();
    sb_mode   = MODE_RR;
    sb_en     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, 16'h0100 * 16'(i + 1));
    in_valid = 4'b0100;
    #1;
    total++;
    if (r_in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL rr_set_ptr3 got=%b want=0100", r_in_ready);
    end
    tick();
    in_valid = 4'b0010;
    #1;
    total++;
    if (r_in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL rr_skip got=%b want=0010", r_in_ready);
    end
    tick();
    in_valid = 4'b0001;
    #1;
    total++;
    if (r_in_ready !== 4'b0001 || r_out_chan !== 2'd1) begin
      bad++;
      $display("FAIL rr_wrap got=%b,%0d want=0001,1", r_in_ready, r_out_chan);
    end
    tick();
    in_valid = 4'b1111;
    #1;
    total++;
    if (r_in_ready !== 4'b0010 || r_out_chan !== 2'd0) begin
      bad++;
      $display("FAIL rr_ptr_after_wrap got=%b,%0d want=0010,0", r_in_ready, r_out_chan);
    end
    tick();
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    sb_mode   = MODE_RR;
    sb_en     = 1'b1;
    out_ready = 1'b1;
    pushes    = 0;
    pops      = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c % 2 == 1) ? 4'b1111 : 4'b0000;
      in_data  = {$urandom, $urandom};
      tick();
      total++;
      if (r_out_valid !== (c % 2 == 1)) begin
        bad++;
        $display("FAIL b2b_valid_c%0d got=%b want=%b", c, r_out_valid, (c % 2 == 1));
      end
    end
    in_valid = 4'b0000;
    tick();
    tick();
    total++;
    if (pushes != 10 || pops != 10 || sbq.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got=push%0d,pop%0d,left%0d want=10,10,0", pushes, pops, sbq.size());
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    sb_en   = 1'b0;
    sb_mode = MODE_FIXED;
    pushes  = 0;
    pops    = 0;
    test_reset();
    test_fixed_basic();
    test_fixed_stall();
    test_random(MODE_FIXED);
    test_rr_fair();
    test_rr_skip_wrap();
    test_back_to_back();
    do_reset();
    test_random(MODE_RR);
    sb_en = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
